// File: rtl/envelope_length.sv
// rtl/envelope_length.sv - per-channel envelope generator and length counter
module envelope_length (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable_240hz,
    input  logic       enable_120hz,
    input  logic       channel_enable,
    input  logic       wr_ctrl,
    input  logic       wr_length,
    input  logic [7:0] data,
    output logic [3:0] volume,
    output logic       active
);

    logic [5:0] ctrl_q,    ctrl_d;
    logic       start_q,   start_d;
    logic [3:0] divider_q, divider_d;
    logic [3:0] decay_q,   decay_d;
    logic [7:0] length_q,  length_d;

    logic       halt;
    logic       const_vol;
    logic [3:0] period;

    assign halt      = ctrl_q[5];
    assign const_vol = ctrl_q[4];
    assign period    = ctrl_q[3:0];

    function automatic logic [7:0] length_lut(input logic [4:0] idx);
        logic [7:0] v;
        case (idx)
            5'd0:  v = 8'd10;   5'd1:  v = 8'd254;  5'd2:  v = 8'd20;   5'd3:  v = 8'd2;
            5'd4:  v = 8'd40;   5'd5:  v = 8'd4;    5'd6:  v = 8'd80;   5'd7:  v = 8'd6;
            5'd8:  v = 8'd160;  5'd9:  v = 8'd8;    5'd10: v = 8'd60;   5'd11: v = 8'd10;
            5'd12: v = 8'd14;   5'd13: v = 8'd12;   5'd14: v = 8'd26;   5'd15: v = 8'd14;
            5'd16: v = 8'd12;   5'd17: v = 8'd16;   5'd18: v = 8'd24;   5'd19: v = 8'd18;
            5'd20: v = 8'd48;   5'd21: v = 8'd20;   5'd22: v = 8'd96;   5'd23: v = 8'd22;
            5'd24: v = 8'd192;  5'd25: v = 8'd24;   5'd26: v = 8'd72;   5'd27: v = 8'd26;
            5'd28: v = 8'd16;   5'd29: v = 8'd28;   5'd30: v = 8'd32;   default: v = 8'd30;
        endcase
        return v;
    endfunction

    always_comb begin
        ctrl_d = wr_ctrl ? data[5:0] : ctrl_q;

        // Disable outranks a load, and a load outranks the half-frame decrement
        length_d = length_q;
        if (!channel_enable)
            length_d = 8'd0;
        else if (wr_length)
            length_d = length_lut(data[7:3]);
        else if (enable_120hz && (length_q != 8'd0) && !halt)
            length_d = length_q - 8'd1;

        start_d   = start_q;
        divider_d = divider_q;
        decay_d   = decay_q;
        if (enable_240hz) begin
            if (start_q) begin
                start_d   = 1'b0;
                decay_d   = 4'd15;
                divider_d = period;
            end else if (divider_q == 4'd0) begin
                divider_d = period;
                if (decay_q != 4'd0)
                    decay_d = decay_q - 4'd1;
                else if (halt)
                    decay_d = 4'd15;
            end else begin
                divider_d = divider_q - 4'd1;
            end
        end
        // A coincident write re-arms start after the tick has consumed the old flag
        if (wr_length)
            start_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q    <= 6'd0;
            start_q   <= 1'b0;
            divider_q <= 4'd0;
            decay_q   <= 4'd0;
            length_q  <= 8'd0;
        end else begin
            ctrl_q    <= ctrl_d;
            start_q   <= start_d;
            divider_q <= divider_d;
            decay_q   <= decay_d;
            length_q  <= length_d;
        end
    end

    assign active = (length_q != 8'd0);
    assign volume = !active ? 4'd0 : (const_vol ? period : decay_q);

endmodule

// File: tb/tb_envelope_length.sv
// tb/tb_envelope_length.sv - directed self-checking bench for envelope_length
module tb_envelope_length;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable_240hz = 1'b0;
    logic       enable_120hz = 1'b0;
    logic       channel_enable = 1'b0;
    logic       wr_ctrl = 1'b0;
    logic       wr_length = 1'b0;
    logic [7:0] data = 8'd0;
    logic [3:0] volume;
    logic       active;

    int checks = 0;
    int failures = 0;

    envelope_length dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .enable_240hz   (enable_240hz),
        .enable_120hz   (enable_120hz),
        .channel_enable (channel_enable),
        .wr_ctrl        (wr_ctrl),
        .wr_length      (wr_length),
        .data           (data),
        .volume         (volume),
        .active         (active)
    );

    always #5 clk = ~clk;

    // One clock with the given strobes high; outputs are settled on return
    task automatic step(input bit wc, input bit wl, input bit q, input bit h, input logic [7:0] d);
        data = d; wr_ctrl = wc; wr_length = wl; enable_240hz = q; enable_120hz = h;
        @(posedge clk); #1;
        wr_ctrl = 0; wr_length = 0; enable_240hz = 0; enable_120hz = 0;
    endtask

    task automatic halves(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 1, 8'h00);
    endtask

    task automatic quarters(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 1, 0, 8'h00);
    endtask

    task automatic test_reset;
        rst_n = 1; channel_enable = 1;
        step(1, 0, 0, 0, 8'h1F);
        step(0, 1, 0, 0, 8'h08);
        // Assert reset mid-cycle; outputs must clear without a clock edge
        #1 rst_n = 0; #1;
        checks++;
        if (active !== 1'b0 || volume !== 4'd0) begin
            failures++;
            $display("FAIL reset_async active=%b volume=%0d required active=0 volume=0", active, volume);
        end
        @(posedge clk); #1 rst_n = 1;
        for (int i = 0; i < 8; i++) step(0, 0, 1, 1, 8'h00);
        checks++;
        if (active !== 1'b0 || volume !== 4'd0) begin
            failures++;
            $display("FAIL reset_ticks active=%b volume=%0d required active=0 volume=0", active, volume);
        end
    endtask

    task automatic test_length_decay;
        step(1, 0, 0, 0, 8'h1F);
        step(0, 1, 0, 0, 8'h08);
        checks++;
        if (active !== 1'b1 || volume !== 4'd15) begin
            failures++;
            $display("FAIL len_load active=%b volume=%0d required active=1 volume=15", active, volume);
        end
        halves(253);
        checks++;
        if (active !== 1'b1) begin
            failures++;
            $display("FAIL len_253 active=%b required 1", active);
        end
        halves(1);
        checks++;
        if (active !== 1'b0 || volume !== 4'd0) begin
            failures++;
            $display("FAIL len_254 active=%b volume=%0d required active=0 volume=0", active, volume);
        end
        halves(3);
        checks++;
        if (active !== 1'b0) begin
            failures++;
            $display("FAIL len_nowrap active=%b required 0", active);
        end
    endtask

    task automatic test_halt_disable;
        step(1, 0, 0, 0, 8'h30);
        step(0, 1, 0, 0, 8'h00);
        halves(20);
        checks++;
        if (active !== 1'b1) begin
            failures++;
            $display("FAIL halt_hold active=%b required 1", active);
        end
        // Release halt; exactly 10 more half ticks must expire the held count
        step(1, 0, 0, 0, 8'h1F);
        halves(9);
        checks++;
        if (active !== 1'b1) begin
            failures++;
            $display("FAIL halt_len9 active=%b required 1", active);
        end
        halves(1);
        checks++;
        if (active !== 1'b0) begin
            failures++;
            $display("FAIL halt_len10 active=%b required 0", active);
        end
        step(0, 1, 0, 0, 8'h00);
        channel_enable = 0;
        step(0, 0, 0, 0, 8'h00);
        checks++;
        if (active !== 1'b0 || volume !== 4'd0) begin
            failures++;
            $display("FAIL disable active=%b volume=%0d required active=0 volume=0", active, volume);
        end
        step(0, 1, 0, 0, 8'h08);
        checks++;
        if (active !== 1'b0) begin
            failures++;
            $display("FAIL disabled_load active=%b required 0", active);
        end
        channel_enable = 1;
        step(0, 0, 0, 0, 8'h00);
        checks++;
        if (active !== 1'b0) begin
            failures++;
            $display("FAIL reenable active=%b required 0", active);
        end
    endtask

    task automatic test_envelope;
        step(1, 0, 0, 0, 8'h02);
        step(0, 1, 0, 0, 8'h40);
        quarters(1);
        checks++;
        if (volume !== 4'd15) begin
            failures++;
            $display("FAIL env_start volume=%0d required 15", volume);
        end
        quarters(2);
        checks++;
        if (volume !== 4'd15) begin
            failures++;
            $display("FAIL env_div volume=%0d required 15", volume);
        end
        quarters(1);
        checks++;
        if (volume !== 4'd14) begin
            failures++;
            $display("FAIL env_step1 volume=%0d required 14", volume);
        end
        quarters(41);
        checks++;
        if (volume !== 4'd1) begin
            failures++;
            $display("FAIL env_44 volume=%0d required 1", volume);
        end
        quarters(1);
        checks++;
        if (volume !== 4'd0) begin
            failures++;
            $display("FAIL env_45 volume=%0d required 0", volume);
        end
        quarters(6);
        checks++;
        if (volume !== 4'd0 || active !== 1'b1) begin
            failures++;
            $display("FAIL env_hold volume=%0d active=%b required volume=0 active=1", volume, active);
        end
        step(1, 0, 0, 0, 8'h22);
        step(0, 1, 0, 0, 8'h40);
        quarters(46);
        checks++;
        if (volume !== 4'd0) begin
            failures++;
            $display("FAIL loop_zero volume=%0d required 0", volume);
        end
        quarters(3);
        checks++;
        if (volume !== 4'd15) begin
            failures++;
            $display("FAIL loop_wrap volume=%0d required 15", volume);
        end
    endtask

    task automatic test_collisions;
        step(1, 0, 0, 0, 8'h1F);
        step(0, 1, 0, 1, 8'h20);
        halves(39);
        checks++;
        if (active !== 1'b1) begin
            failures++;
            $display("FAIL coll_half39 active=%b required 1", active);
        end
        halves(1);
        checks++;
        if (active !== 1'b0) begin
            failures++;
            $display("FAIL coll_half40 active=%b required 0", active);
        end
        step(1, 0, 0, 0, 8'h02);
        step(0, 1, 0, 0, 8'h40);
        quarters(4);
        step(0, 1, 1, 0, 8'h40);
        checks++;
        if (volume !== 4'd14) begin
            failures++;
            $display("FAIL coll_q_same volume=%0d required 14", volume);
        end
        quarters(1);
        checks++;
        if (volume !== 4'd15) begin
            failures++;
            $display("FAIL coll_q_next volume=%0d required 15", volume);
        end
        quarters(3);
        checks++;
        if (volume !== 4'd14) begin
            failures++;
            $display("FAIL coll_q_reload volume=%0d required 14", volume);
        end
        // Control write with a tick: the tick still sees period 2
        step(1, 0, 1, 0, 8'h00);
        step(0, 0, 1, 0, 8'h00);
        checks++;
        if (volume !== 4'd14) begin
            failures++;
            $display("FAIL coll_ctrl volume=%0d required 14", volume);
        end
        quarters(1);
        checks++;
        if (volume !== 4'd13) begin
            failures++;
            $display("FAIL coll_ctrl_new volume=%0d required 13", volume);
        end
    endtask

    initial begin
        test_reset();
        test_length_decay();
        test_halt_disable();
        test_envelope();
        test_collisions();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
